// File: rtl/dual_ram_arbiter.sv
// Two-requester front end for a dual-port RAM: independent round-robin
// arbitration of the write and read ports, read/write collision stalls, and read return.
module dual_ram_arbiter #(
  parameter int RAM_WIDTH = 8,
  parameter int ADDR_SIZE = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_SIZE-1:0] a_addr,
  input  logic [RAM_WIDTH-1:0] a_wdata,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [RAM_WIDTH-1:0] a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_SIZE-1:0] b_addr,
  input  logic [RAM_WIDTH-1:0] b_wdata,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [RAM_WIDTH-1:0] b_rdata,
  output logic                 ram_read,
  output logic                 ram_write,
  output logic [ADDR_SIZE-1:0] ram_rd_addr,
  output logic [ADDR_SIZE-1:0] ram_wr_addr,
  output logic [RAM_WIDTH-1:0] ram_data_in,
  input  logic [RAM_WIDTH-1:0] ram_data_out,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Pointer / selector encoding: 0 = requester A, 1 = requester B.
  logic wr_ptr, rd_ptr;
  logic rd_pend, rd_owner;
  logic a_wc, b_wc, a_rc, b_rc;
  logic wr_any, rd_any, wr_sel, rd_sel;
  logic collide, wr_gnt, rd_gnt;
  logic [ADDR_SIZE-1:0] wr_addr_sel, rd_addr_sel;

  always_comb begin
    a_wc        = a_req & a_we;
    b_wc        = b_req & b_we;
    a_rc        = a_req & ~a_we;
    b_rc        = b_req & ~b_we;
    wr_any      = a_wc | b_wc;
    rd_any      = a_rc | b_rc;
    wr_sel      = (a_wc & b_wc) ? wr_ptr : b_wc;
    rd_sel      = (a_rc & b_rc) ? rd_ptr : b_rc;
    wr_addr_sel = wr_sel ? b_addr : a_addr;
    rd_addr_sel = rd_sel ? b_addr : a_addr;
    // A read hitting the address being written this cycle waits one cycle.
    collide     = ~reset & wr_any & rd_any & (wr_addr_sel == rd_addr_sel);
    wr_gnt      = ~reset & wr_any;
    rd_gnt      = ~reset & rd_any & ~collide;

    a_gnt       = (wr_gnt & ~wr_sel) | (rd_gnt & ~rd_sel);
    b_gnt       = (wr_gnt &  wr_sel) | (rd_gnt &  rd_sel);

    ram_write   = wr_gnt;
    ram_read    = rd_gnt;
    ram_wr_addr = wr_gnt ? wr_addr_sel : '0;
    ram_data_in = wr_gnt ? (wr_sel ? b_wdata : a_wdata) : '0;
    ram_rd_addr = rd_gnt ? rd_addr_sel : '0;
  end

  // Arbitration state and read-return tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      rd_pend   <= 1'b0;
      rd_owner  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (wr_gnt) wr_ptr <= ~wr_sel;
      if (rd_gnt) begin
        rd_ptr   <= ~rd_sel;
        rd_owner <= rd_sel;
      end
      rd_pend <= rd_gnt;
      if (collide) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  always_comb begin
    a_rvalid = rd_pend & ~rd_owner;
    b_rvalid = rd_pend &  rd_owner;
    a_rdata  = a_rvalid ? ram_data_out : '0;
    b_rdata  = b_rvalid ? ram_data_out : '0;
  end

endmodule
